axi_lite_master: RTL and testbench
==================================

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the address width on the request side and on AR/AW.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data width on the request side, W and R.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have request ports req_valid in 1, req_ready out 1, req_we in 1 (1=write), req_addr in ADDR_W, req_wdata in DATA_W and req_wmask in 8.
REQ-006 The block SHALL have response ports rsp_valid out 1 (single-cycle pulse) and rsp_rdata out DATA_W (write: don't-care).
REQ-007 The block SHALL have AXI read ports maxi_araddr out ADDR_W, maxi_arvalid out 1, maxi_arready in 1, maxi_rvalid in 1, maxi_rready out 1 and maxi_rdata in DATA_W.
REQ-008 The block SHALL have AXI write ports maxi_awaddr out ADDR_W, maxi_awvalid out 1, maxi_awready in 1, maxi_wdata out DATA_W, maxi_wvalid out 1, maxi_wready in 1, maxi_bvalid in 1, maxi_bready out 1 and wmask out 8 (sideband).

Function
REQ-009 The FSM SHALL have states IDLE, RD_AR, RD_R, WR_AW_W and WR_B.
REQ-010 req_ready SHALL be 1 exactly when the state is IDLE; acceptance is req_valid&&req_ready.
REQ-011 On acceptance the block SHALL register req_addr, req_wdata and req_wmask, and go to RD_AR (req_we=0) or WR_AW_W (req_we=1).
REQ-012 maxi_araddr, maxi_awaddr, maxi_wdata and wmask SHALL drive the registered values and stay stable from acceptance until the return to IDLE.
REQ-013 In RD_AR, maxi_arvalid SHALL be 1; it drops the cycle after the AR handshake, and the state goes to RD_R.
REQ-014 In RD_R, maxi_rready SHALL be 1; on maxi_rvalid&&maxi_rready, rsp_rdata captures maxi_rdata, rsp_valid=1 next cycle, and the state goes to IDLE.
REQ-015 In WR_AW_W, maxi_awvalid and maxi_wvalid SHALL both assert in the first cycle, and each SHALL deassert independently after its own handshake, tracked by flags aw_done/w_done.
REQ-016 The state SHALL move to WR_B once aw_done and w_done are both set; AW and W handshakes in the same cycle go directly to WR_B.
REQ-017 In WR_B, maxi_bready SHALL be 1; on maxi_bvalid&&maxi_bready, rsp_valid=1 next cycle, the state goes to IDLE, and aw_done/w_done clear.
REQ-018 Once asserted, a VALID output SHALL NOT deassert before its handshake and SHALL NOT depend combinationally on the matching READY.
REQ-019 At most one transaction SHALL be outstanding; reads and writes are never overlapped.
REQ-020 rsp_valid SHALL be high for exactly one cycle per transaction, the same cycle the state returns to IDLE.
REQ-021 Minimum read latency SHALL be: accept at T, arvalid at T+1, rready at T+2, rsp_valid at T+3 (slave with arready=1 and rvalid at T+2).
REQ-022 A new request SHALL be acceptable in the cycle rsp_valid is high.
REQ-023 rsp_rdata SHALL hold its value until the next R handshake.

Reset
REQ-024 While rst=1, the state SHALL be IDLE and all VALID/READY outputs to AXI SHALL be 0, with rsp_valid=0, aw_done=w_done=0, rsp_rdata=0 and address registers=0x80000000.
REQ-025 rst asserted mid-transaction SHALL abort it at the next edge with no rsp_valid pulse; req_ready=1 the first cycle after rst falls.

Verification
REQ-026 Read with an immediate slave: req addr 0x80000004, slave returns 0xDEADBEEF -> arvalid one cycle, araddr=0x80000004, rsp_valid at T+3 with rsp_rdata=0xDEADBEEF.
REQ-027 Write with awready at +1 and wready at +3 cycles: addr 0x80000010, data 0x12345678, wmask 0x0F -> awvalid drops after +1, wvalid held until +3, then bready, rsp_valid one cycle after bvalid.
REQ-028 Back-pressure: arready held low for 5 cycles -> arvalid and araddr stable all 5 cycles, req_ready=0 throughout.
REQ-029 Back-to-back: second request held valid during the rsp_valid cycle -> accepted that cycle; no idle gap beyond REQ-022.
REQ-030 Reset during WR_B -> the next cycle has all AXI valids 0, bready=0 and no rsp_valid; a following read completes normally.
REQ-031 Simultaneous AW and W handshake in the first write cycle -> WR_B entered on the next cycle.

Source files
------------

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns a simple request/response port
// into AR/R or AW/W/B transactions, one at a time.
module axi_lite_master #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   // request / response side
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [7:0]        req_wmask,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   // AXI read channels
   output logic [ADDR_W-1:0] maxi_araddr,
   output logic              maxi_arvalid,
   input  logic              maxi_arready,
   input  logic              maxi_rvalid,
   output logic              maxi_rready,
   input  logic [DATA_W-1:0] maxi_rdata,
   // AXI write channels
   output logic [ADDR_W-1:0] maxi_awaddr,
   output logic              maxi_awvalid,
   input  logic              maxi_awready,
   output logic [DATA_W-1:0] maxi_wdata,
   output logic              maxi_wvalid,
   input  logic              maxi_wready,
   input  logic              maxi_bvalid,
   output logic              maxi_bready,
   output logic [7:0]        wmask
);

   typedef enum logic [2:0] {
      IDLE,
      RD_AR,
      RD_R,
      WR_AW_W,
      WR_B
   } state_t;

   localparam logic [ADDR_W-1:0] RST_ADDR = ADDR_W'(32'h8000_0000);

   state_t              r_state;
   state_t              w_next;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [7:0]          r_wmask;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_rsp_valid;
   logic                r_aw_done;
   logic                r_w_done;

   logic                w_accept;
   logic                w_ar_fire;
   logic                w_r_fire;
   logic                w_aw_fire;
   logic                w_w_fire;
   logic                w_b_fire;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Valids are decoded from registered state/flags only, never from READY.
   always_comb begin
      req_ready    = 1'b0;
      maxi_arvalid = 1'b0;
      maxi_rready  = 1'b0;
      maxi_awvalid = 1'b0;
      maxi_wvalid  = 1'b0;
      maxi_bready  = 1'b0;
      w_next       = r_state;

      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_next = req_we ? WR_AW_W : RD_AR;
            end
         end
         RD_AR: begin
            maxi_arvalid = 1'b1;
            if (maxi_arready) begin
               w_next = RD_R;
            end
         end
         RD_R: begin
            maxi_rready = 1'b1;
            if (maxi_rvalid) begin
               w_next = IDLE;
            end
         end
         WR_AW_W: begin
            maxi_awvalid = !r_aw_done;
            maxi_wvalid  = !r_w_done;
            if ((r_aw_done || maxi_awready) && (r_w_done || maxi_wready)) begin
               w_next = WR_B;
            end
         end
         WR_B: begin
            maxi_bready = 1'b1;
            if (maxi_bvalid) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_accept  = req_valid    && req_ready;
   assign w_ar_fire = maxi_arvalid && maxi_arready;
   assign w_r_fire  = maxi_rvalid  && maxi_rready;
   assign w_aw_fire = maxi_awvalid && maxi_awready;
   assign w_w_fire  = maxi_wvalid  && maxi_wready;
   assign w_b_fire  = maxi_bvalid  && maxi_bready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr      <= RST_ADDR;
         r_wdata     <= '0;
         r_wmask     <= '0;
         r_rdata     <= '0;
         r_rsp_valid <= 1'b0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
      end else begin
         r_rsp_valid <= w_r_fire || w_b_fire;
         if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wmask <= req_wmask;
         end
         if (w_r_fire) begin
            r_rdata <= maxi_rdata;
         end
         if (w_b_fire) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end else begin
            if (w_aw_fire) begin
               r_aw_done <= 1'b1;
            end
            if (w_w_fire) begin
               r_w_done <= 1'b1;
            end
         end
      end
   end

   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rdata;
   assign maxi_araddr = r_addr;
   assign maxi_awaddr = r_addr;
   assign maxi_wdata  = r_wdata;
   assign wmask       = r_wmask;

   // w_ar_fire only documents the AR handshake; the state decode already covers it.
   logic w_unused;
   assign w_unused = w_ar_fire;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed self-checking bench for axi_lite_master: the DUT plays against a
// hand-driven AXI slave, and expected values are written out cycle by cycle.
module tb_axi_lite_master;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [7:0]  req_wmask;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [31:0] maxi_araddr;
   logic        maxi_arvalid;
   logic        maxi_arready;
   logic        maxi_rvalid;
   logic        maxi_rready;
   logic [31:0] maxi_rdata;
   logic [31:0] maxi_awaddr;
   logic        maxi_awvalid;
   logic        maxi_awready;
   logic [31:0] maxi_wdata;
   logic        maxi_wvalid;
   logic        maxi_wready;
   logic        maxi_bvalid;
   logic        maxi_bready;
   logic [7:0]  wmask;

   int unsigned n_checks;
   int unsigned n_pass;

   axi_lite_master #(
      .ADDR_W (32),
      .DATA_W (32)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_wmask    (req_wmask),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .maxi_araddr  (maxi_araddr),
      .maxi_arvalid (maxi_arvalid),
      .maxi_arready (maxi_arready),
      .maxi_rvalid  (maxi_rvalid),
      .maxi_rready  (maxi_rready),
      .maxi_rdata   (maxi_rdata),
      .maxi_awaddr  (maxi_awaddr),
      .maxi_awvalid (maxi_awvalid),
      .maxi_awready (maxi_awready),
      .maxi_wdata   (maxi_wdata),
      .maxi_wvalid  (maxi_wvalid),
      .maxi_wready  (maxi_wready),
      .maxi_bvalid  (maxi_bvalid),
      .maxi_bready  (maxi_bready),
      .wmask        (wmask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs are driven and outputs sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_axi(input string tag);
      check({tag, ".arvalid"}, maxi_arvalid, 1'b0);
      check({tag, ".awvalid"}, maxi_awvalid, 1'b0);
      check({tag, ".wvalid"},  maxi_wvalid,  1'b0);
      check({tag, ".rready"},  maxi_rready,  1'b0);
      check({tag, ".bready"},  maxi_bready,  1'b0);
      check({tag, ".rsp_valid"}, rsp_valid,  1'b0);
   endtask

   initial begin
      n_checks     = 0;
      n_pass       = 0;
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      req_wmask    = '0;
      maxi_arready = 1'b0;
      maxi_rvalid  = 1'b0;
      maxi_rdata   = '0;
      maxi_awready = 1'b0;
      maxi_wready  = 1'b0;
      maxi_bvalid  = 1'b0;

      // ---- reset state
      tick();
      tick();
      check_idle_axi("rst");
      check("rst.req_ready", req_ready, 1'b1);
      check("rst.rsp_rdata", rsp_rdata, 32'h0);
      check("rst.araddr", maxi_araddr, 32'h8000_0000);
      check("rst.awaddr", maxi_awaddr, 32'h8000_0000);
      rst = 1'b0;
      tick();

      // ---- read, immediate slave: accept T, arvalid T+1, rready T+2, rsp T+3
      req_valid    = 1'b1;
      req_we       = 1'b0;
      req_addr     = 32'h8000_0004;
      maxi_arready = 1'b1;
      check("rd.T.req_ready", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      check("rd.T1.arvalid", maxi_arvalid, 1'b1);
      check("rd.T1.araddr", maxi_araddr, 32'h8000_0004);
      check("rd.T1.req_ready", req_ready, 1'b0);
      check("rd.T1.rready", maxi_rready, 1'b0);
      tick();
      check("rd.T2.arvalid", maxi_arvalid, 1'b0);
      check("rd.T2.rready", maxi_rready, 1'b1);
      maxi_rvalid = 1'b1;
      maxi_rdata  = 32'hDEAD_BEEF;
      tick();
      maxi_rvalid  = 1'b0;
      maxi_rdata   = 32'h0;
      maxi_arready = 1'b0;
      check("rd.T3.rsp_valid", rsp_valid, 1'b1);
      check("rd.T3.rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check("rd.T3.req_ready", req_ready, 1'b1);
      check("rd.T3.rready", maxi_rready, 1'b0);
      tick();
      check("rd.T4.rsp_valid", rsp_valid, 1'b0);
      check("rd.T4.rdata_hold", rsp_rdata, 32'hDEAD_BEEF);

      // ---- write: awready at +1, wready at +3
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h8000_0010;
      req_wdata = 32'h1234_5678;
      req_wmask = 8'h0F;
      tick();
      req_valid = 1'b0;
      req_wdata = 32'hFFFF_FFFF;
      check("wr.1.awvalid", maxi_awvalid, 1'b1);
      check("wr.1.wvalid", maxi_wvalid, 1'b1);
      check("wr.1.awaddr", maxi_awaddr, 32'h8000_0010);
      check("wr.1.wdata", maxi_wdata, 32'h1234_5678);
      check("wr.1.wmask", wmask, 8'h0F);
      maxi_awready = 1'b1;
      tick();
      maxi_awready = 1'b0;
      check("wr.2.awvalid", maxi_awvalid, 1'b0);
      check("wr.2.wvalid", maxi_wvalid, 1'b1);
      check("wr.2.bready", maxi_bready, 1'b0);
      tick();
      check("wr.3.wvalid", maxi_wvalid, 1'b1);
      check("wr.3.wdata", maxi_wdata, 32'h1234_5678);
      maxi_wready = 1'b1;
      tick();
      maxi_wready = 1'b0;
      check("wr.4.wvalid", maxi_wvalid, 1'b0);
      check("wr.4.bready", maxi_bready, 1'b1);
      check("wr.4.rsp_valid", rsp_valid, 1'b0);
      maxi_bvalid = 1'b1;
      tick();
      maxi_bvalid = 1'b0;
      check("wr.5.rsp_valid", rsp_valid, 1'b1);
      check("wr.5.bready", maxi_bready, 1'b0);
      check("wr.5.req_ready", req_ready, 1'b1);
      tick();
      check("wr.6.rsp_valid", rsp_valid, 1'b0);

      // ---- read with arready held low for 5 cycles
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h8000_0020;
      tick();
      req_valid = 1'b0;
      req_addr  = 32'h0;
      for (int i = 0; i < 5; i++) begin
         check("bp.arvalid", maxi_arvalid, 1'b1);
         check("bp.araddr", maxi_araddr, 32'h8000_0020);
         check("bp.req_ready", req_ready, 1'b0);
         tick();
      end
      check("bp.end.arvalid", maxi_arvalid, 1'b1);
      maxi_arready = 1'b1;
      tick();
      maxi_arready = 1'b0;
      check("bp.rready", maxi_rready, 1'b1);
      maxi_rvalid = 1'b1;
      maxi_rdata  = 32'hCAFE_F00D;
      // second request already pending; it must not be taken before rsp
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h8000_0030;
      req_wdata = 32'hA5A5_A5A5;
      req_wmask = 8'h3C;
      tick();
      maxi_rvalid = 1'b0;
      check("b2b.rsp_valid", rsp_valid, 1'b1);
      check("b2b.rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
      check("b2b.req_ready", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      check("b2b.awvalid", maxi_awvalid, 1'b1);
      check("b2b.wvalid", maxi_wvalid, 1'b1);
      check("b2b.awaddr", maxi_awaddr, 32'h8000_0030);
      check("b2b.wmask", wmask, 8'h3C);
      check("b2b.rsp_low", rsp_valid, 1'b0);

      // ---- simultaneous AW and W handshake, then reset during WR_B
      maxi_awready = 1'b1;
      maxi_wready  = 1'b1;
      tick();
      maxi_awready = 1'b0;
      maxi_wready  = 1'b0;
      check("sim.bready", maxi_bready, 1'b1);
      check("sim.awvalid", maxi_awvalid, 1'b0);
      check("sim.wvalid", maxi_wvalid, 1'b0);
      rst         = 1'b1;
      maxi_bvalid = 1'b1;
      tick();
      maxi_bvalid = 1'b0;
      check_idle_axi("wrb_rst");
      check("wrb_rst.araddr", maxi_araddr, 32'h8000_0000);
      rst = 1'b0;
      tick();
      check("post_rst.req_ready", req_ready, 1'b1);
      check("post_rst.rsp_valid", rsp_valid, 1'b0);

      // ---- a normal read after the aborted write
      req_valid    = 1'b1;
      req_we       = 1'b0;
      req_addr     = 32'h8000_0044;
      maxi_arready = 1'b1;
      tick();
      req_valid = 1'b0;
      check("rd2.araddr", maxi_araddr, 32'h8000_0044);
      check("rd2.awvalid", maxi_awvalid, 1'b0);
      tick();
      maxi_arready = 1'b0;
      maxi_rvalid  = 1'b1;
      maxi_rdata   = 32'h0BAD_F00D;
      tick();
      maxi_rvalid = 1'b0;
      check("rd2.rsp_valid", rsp_valid, 1'b1);
      check("rd2.rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
      tick();
      check("rd2.rsp_once", rsp_valid, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
